// File: rtl/swo_itm_packetiser_if.sv
// Byte input and packet output bundle between the SWO byte decoder,
// the ITM packetiser and the downstream packet consumer.
interface swo_itm_packetiser_if;
  logic        byte_avail;
  logic [7:0]  byte_in;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [1:0]  pkt_type;
  logic [7:0]  pkt_hdr;
  logic [4:0]  pkt_addr;
  logic        pkt_hw;
  logic [2:0]  pkt_len;
  logic [31:0] pkt_data;
  logic        synced;
  logic        sync_lost;
  logic [7:0]  drop_count;

  // packetiser side
  modport master (
    input  byte_avail, byte_in, pkt_ready,
    output pkt_valid, pkt_type, pkt_hdr, pkt_addr, pkt_hw, pkt_len, pkt_data,
           synced, sync_lost, drop_count
  );

  // byte source / packet consumer side
  modport slave (
    output byte_avail, byte_in, pkt_ready,
    input  pkt_valid, pkt_type, pkt_hdr, pkt_addr, pkt_hw, pkt_len, pkt_data,
           synced, sync_lost, drop_count
  );
endinterface

// File: rtl/swo_itm_packetiser.sv
// Frames toggle-flagged SWO bytes into ITM/DWT packets (sync, overflow,
// source, protocol) and presents them on a single-entry valid/ready slot.
module swo_itm_packetiser #(
  parameter int MIN_SYNC_ZEROS = 5,
  parameter int MAX_PROTO_CONT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  swo_itm_packetiser_if.master  bus
);

  localparam logic [2:0] MIN_Z = 3'(MIN_SYNC_ZEROS);
  localparam logic [2:0] MAX_C = 3'(MAX_PROTO_CONT);
  localparam logic [1:0] T_SYNC = 2'd0;
  localparam logic [1:0] T_OVF  = 2'd1;
  localparam logic [1:0] T_SRC  = 2'd2;
  localparam logic [1:0] T_PROT = 2'd3;

  typedef enum logic [1:0] {ST_UNSYNC, ST_HDR, ST_SRC_PAY, ST_PROTO_CONT} state_t;

  state_t      state_q, state_d;
  logic        avail_q, avail_d, primed_q, primed_d;
  logic [2:0]  zcnt_q, zcnt_d, cnt_q, cnt_d;
  logic [7:0]  hdr_q, hdr_d, drop_q, drop_d;
  logic [31:0] data_q, data_d;
  logic        synced_q, synced_d, lost_q, lost_d;
  logic        pkt_valid_q, pkt_valid_d, pkt_hw_q, pkt_hw_d;
  logic [1:0]  pkt_type_q, pkt_type_d;
  logic [7:0]  pkt_hdr_q, pkt_hdr_d;
  logic [4:0]  pkt_addr_q, pkt_addr_d;
  logic [2:0]  pkt_len_q, pkt_len_d;
  logic [31:0] pkt_data_q, pkt_data_d;

  logic        new_byte_s, emit_s;
  logic [7:0]  b_s, em_hdr_s;
  logic [1:0]  em_type_s;
  logic [2:0]  em_len_s, cnt_inc_s, need_s;
  logic [31:0] em_data_s, stored_s;

  // Byte strobe, framing state machine and output slot next-state logic
  always_comb begin
    avail_d     = bus.byte_avail;
    primed_d    = 1'b1;
    state_d     = state_q;
    zcnt_d      = zcnt_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    data_d      = data_q;
    synced_d    = synced_q;
    lost_d      = lost_q;
    drop_d      = drop_q;
    pkt_valid_d = pkt_valid_q;
    pkt_type_d  = pkt_type_q;
    pkt_hdr_d   = pkt_hdr_q;
    pkt_addr_d  = pkt_addr_q;
    pkt_hw_d    = pkt_hw_q;
    pkt_len_d   = pkt_len_q;
    pkt_data_d  = pkt_data_q;
    emit_s      = 1'b0;
    em_type_s   = T_SYNC;
    em_hdr_s    = 8'h00;
    em_len_s    = 3'd0;
    em_data_s   = 32'd0;

    new_byte_s = primed_q & (bus.byte_avail ^ avail_q);
    b_s        = bus.byte_in;
    cnt_inc_s  = cnt_q + 3'd1;
    stored_s   = data_q | ({24'd0, b_s} << {cnt_q[1:0], 3'b000});
    need_s     = (hdr_q[1:0] == 2'b11) ? 3'd4 : {1'b0, hdr_q[1:0]};

    if (new_byte_s) begin
      if (b_s == 8'h00) begin
        zcnt_d = (zcnt_q == 3'd7) ? 3'd7 : zcnt_q + 3'd1;
      end else begin
        zcnt_d = 3'd0;
      end

      // Sync wins from any state and silently discards a partial packet
      if ((b_s == 8'h80) && (zcnt_q >= MIN_Z)) begin
        state_d   = ST_HDR;
        synced_d  = 1'b1;
        emit_s    = 1'b1;
        em_type_s = T_SYNC;
        em_hdr_s  = 8'h80;
      end else begin
        case (state_q)
          ST_HDR: begin
            if (b_s == 8'h00) begin
              state_d = ST_HDR;
            end else if (b_s == 8'h70) begin
              emit_s    = 1'b1;
              em_type_s = T_OVF;
              em_hdr_s  = b_s;
            end else if (b_s[1:0] != 2'b00) begin
              hdr_d   = b_s;
              cnt_d   = 3'd0;
              data_d  = 32'd0;
              state_d = ST_SRC_PAY;
            end else if (!b_s[7]) begin
              emit_s    = 1'b1;
              em_type_s = T_PROT;
              em_hdr_s  = b_s;
            end else begin
              hdr_d   = b_s;
              cnt_d   = 3'd0;
              data_d  = 32'd0;
              state_d = ST_PROTO_CONT;
            end
          end
          ST_SRC_PAY: begin
            data_d = stored_s;
            cnt_d  = cnt_inc_s;
            if (cnt_inc_s == need_s) begin
              emit_s    = 1'b1;
              em_type_s = T_SRC;
              em_hdr_s  = hdr_q;
              em_len_s  = cnt_inc_s;
              em_data_s = stored_s;
              state_d   = ST_HDR;
            end else begin
              state_d = ST_SRC_PAY;
            end
          end
          ST_PROTO_CONT: begin
            data_d = stored_s;
            cnt_d  = cnt_inc_s;
            if (!b_s[7]) begin
              emit_s    = 1'b1;
              em_type_s = T_PROT;
              em_hdr_s  = hdr_q;
              em_len_s  = cnt_inc_s;
              em_data_s = stored_s;
              state_d   = ST_HDR;
            end else if (cnt_inc_s == MAX_C) begin
              state_d  = ST_UNSYNC;
              synced_d = 1'b0;
              lost_d   = 1'b1;
            end else begin
              state_d = ST_PROTO_CONT;
            end
          end
          default: begin
            state_d = ST_UNSYNC;
          end
        endcase
      end
    end else begin
      zcnt_d = zcnt_q;
    end

    // Single-entry slot: load when free or being drained this cycle, else drop
    if (emit_s) begin
      if (!pkt_valid_q || bus.pkt_ready) begin
        pkt_valid_d = 1'b1;
        pkt_type_d  = em_type_s;
        pkt_hdr_d   = em_hdr_s;
        pkt_addr_d  = (em_type_s == T_SRC) ? em_hdr_s[7:3] : 5'd0;
        pkt_hw_d    = (em_type_s == T_SRC) ? em_hdr_s[2] : 1'b0;
        pkt_len_d   = em_len_s;
        pkt_data_d  = em_data_s;
      end else begin
        drop_d = (drop_q == 8'hff) ? 8'hff : drop_q + 8'd1;
      end
    end else if (pkt_valid_q && bus.pkt_ready) begin
      pkt_valid_d = 1'b0;
    end else begin
      pkt_valid_d = pkt_valid_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_UNSYNC;
      avail_q     <= 1'b0;
      primed_q    <= 1'b0;
      zcnt_q      <= 3'd0;
      cnt_q       <= 3'd0;
      hdr_q       <= 8'd0;
      data_q      <= 32'd0;
      synced_q    <= 1'b0;
      lost_q      <= 1'b0;
      drop_q      <= 8'd0;
      pkt_valid_q <= 1'b0;
      pkt_type_q  <= 2'd0;
      pkt_hdr_q   <= 8'd0;
      pkt_addr_q  <= 5'd0;
      pkt_hw_q    <= 1'b0;
      pkt_len_q   <= 3'd0;
      pkt_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      avail_q     <= avail_d;
      primed_q    <= primed_d;
      zcnt_q      <= zcnt_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      data_q      <= data_d;
      synced_q    <= synced_d;
      lost_q      <= lost_d;
      drop_q      <= drop_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_type_q  <= pkt_type_d;
      pkt_hdr_q   <= pkt_hdr_d;
      pkt_addr_q  <= pkt_addr_d;
      pkt_hw_q    <= pkt_hw_d;
      pkt_len_q   <= pkt_len_d;
      pkt_data_q  <= pkt_data_d;
    end
  end

  assign bus.pkt_valid  = pkt_valid_q;
  assign bus.pkt_type   = pkt_type_q;
  assign bus.pkt_hdr    = pkt_hdr_q;
  assign bus.pkt_addr   = pkt_addr_q;
  assign bus.pkt_hw     = pkt_hw_q;
  assign bus.pkt_len    = pkt_len_q;
  assign bus.pkt_data   = pkt_data_q;
  assign bus.synced     = synced_q;
  assign bus.sync_lost  = lost_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_swo_itm_packetiser.sv
// Self-checking bench for swo_itm_packetiser: directed scenarios plus a
// randomized byte/backpressure run against a packet-level reference model.
module tb_swo_itm_packetiser;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  swo_itm_packetiser_if bus ();

  swo_itm_packetiser #(.MIN_SYNC_ZEROS(5), .MAX_PROTO_CONT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  typ;
    logic [7:0]  hdr;
    logic [4:0]  addr;
    logic        hw;
    logic [2:0]  len;
    logic [31:0] data;
  } pkt_t;

  // Reference model: mode 0=unsynced, 1=expect header, 2=source payload, 3=protocol continuation
  int         m_mode;
  int         m_zeros;
  int         m_need;
  logic [7:0] m_hdr;
  logic [7:0] m_pay[$];
  bit         m_synced, m_lost, m_valid;
  int         m_drop;
  pkt_t       m_slot;

  function automatic void m_reset();
    m_mode = 0; m_zeros = 0; m_need = 0; m_hdr = 8'h00; m_pay.delete();
    m_synced = 1'b0; m_lost = 1'b0; m_valid = 1'b0; m_drop = 0; m_slot = '0;
  endfunction

  function automatic pkt_t make_pkt(input logic [1:0] t, input logic [7:0] h);
    pkt_t p;
    p.typ  = t;
    p.hdr  = h;
    p.addr = (t == 2'd2) ? h[7:3] : 5'd0;
    p.hw   = (t == 2'd2) ? h[2] : 1'b0;
    p.len  = 3'(m_pay.size());
    p.data = 32'd0;
    foreach (m_pay[i]) p.data = p.data + (32'(m_pay[i]) << (8 * i));
    return p;
  endfunction

  task automatic model_edge(input bit has, input logic [7:0] b, input bit rdy);
    bit   emitted = 1'b0;
    pkt_t p = '0;
    if (has) begin
      if (b == 8'h80 && m_zeros >= 5) begin
        m_pay.delete();
        m_mode = 1; m_synced = 1'b1;
        p = make_pkt(2'd0, 8'h80); emitted = 1'b1;
      end else if (m_mode == 1) begin
        if (b == 8'h70) begin
          p = make_pkt(2'd1, b); emitted = 1'b1;
        end else if (b != 8'h00 && b[1:0] != 2'b00) begin
          m_hdr = b; m_need = 1 << (b[1:0] - 1); m_mode = 2;
        end else if (b != 8'h00 && !b[7]) begin
          p = make_pkt(2'd3, b); emitted = 1'b1;
        end else if (b != 8'h00) begin
          m_hdr = b; m_mode = 3;
        end
      end else if (m_mode == 2) begin
        m_pay.push_back(b);
        if (m_pay.size() == m_need) begin
          p = make_pkt(2'd2, m_hdr); emitted = 1'b1; m_pay.delete(); m_mode = 1;
        end
      end else if (m_mode == 3) begin
        m_pay.push_back(b);
        if (!b[7]) begin
          p = make_pkt(2'd3, m_hdr); emitted = 1'b1; m_pay.delete(); m_mode = 1;
        end else if (m_pay.size() == 4) begin
          m_pay.delete(); m_mode = 0; m_synced = 1'b0; m_lost = 1'b1;
        end
      end
      m_zeros = (b == 8'h00) ? m_zeros + 1 : 0;
    end
    if (emitted) begin
      if (!m_valid || rdy) begin
        m_slot = p; m_valid = 1'b1;
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive inputs at the falling edge, returns just after the rising edge
  task automatic cycle(input bit has, input logic [7:0] b, input bit rdy);
    @(negedge clk);
    bus.pkt_ready = rdy;
    if (has) begin
      bus.byte_in    = b;
      bus.byte_avail = ~bus.byte_avail;
    end else begin
      bus.byte_in = 8'($urandom);
    end
    model_edge(has, b, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    cycle(1'b1, b, rdy);
  endtask

  task automatic send_sync();
    repeat (5) send(8'h00, 1'b1);
    send(8'h80, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic assert_reset_mid();
    @(posedge clk);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.byte_avail = 1'b1;
    bus.byte_in    = 8'h00;
    bus.pkt_ready  = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.pkt_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.pkt_valid); else n_pass++;
    n_checks++; if ({bus.synced, bus.sync_lost} !== 2'b00) $display("FAIL reset_sync got %b want 00", {bus.synced, bus.sync_lost}); else n_pass++;
    n_checks++; if (bus.drop_count !== 8'd0) $display("FAIL reset_drop got %0d want 0", bus.drop_count); else n_pass++;
    n_checks++; if ({bus.pkt_type, bus.pkt_hdr, bus.pkt_addr, bus.pkt_hw, bus.pkt_len, bus.pkt_data} !== 51'd0)
      $display("FAIL reset_fields got %h want 0", {bus.pkt_type, bus.pkt_hdr, bus.pkt_addr, bus.pkt_hw, bus.pkt_len, bus.pkt_data}); else n_pass++;
    release_reset();
    // Priming edge must not count as a zero byte: four zeros are one short
    repeat (4) send(8'h00, 1'b1);
    send(8'h80, 1'b1);
    n_checks++; if ({bus.synced, bus.pkt_valid} !== 2'b00) $display("FAIL prime_no_sync got %b want 00", {bus.synced, bus.pkt_valid}); else n_pass++;
  endtask

  task automatic test_sync();
    repeat (5) send(8'h00, 1'b1);
    send(8'h80, 1'b1);
    n_checks++; if ({bus.pkt_valid, bus.pkt_type, bus.pkt_hdr, bus.pkt_len, bus.pkt_data} !== {1'b1, 2'd0, 8'h80, 3'd0, 32'd0})
      $display("FAIL sync_pkt got v=%0b t=%0d h=%h l=%0d d=%h want 1 0 80 0 0", bus.pkt_valid, bus.pkt_type, bus.pkt_hdr, bus.pkt_len, bus.pkt_data); else n_pass++;
    n_checks++; if (bus.synced !== 1'b1) $display("FAIL sync_flag got %0b want 1", bus.synced); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1);
    n_checks++; if (bus.pkt_valid !== 1'b0) $display("FAIL sync_accept got %0b want 0", bus.pkt_valid); else n_pass++;
  endtask

  task automatic test_source();
    assert_reset_mid();
    release_reset();
    send(8'h01, 1'b1);
    send(8'hAA, 1'b1);
    n_checks++; if ({bus.pkt_valid, bus.synced} !== 2'b00) $display("FAIL presync_ignored got %b want 00", {bus.pkt_valid, bus.synced}); else n_pass++;
    send_sync();
    send(8'h0B, 1'b1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    n_checks++; if (bus.pkt_valid !== 1'b0) $display("FAIL src_early got %0b want 0", bus.pkt_valid); else n_pass++;
    send(8'h44, 1'b1);
    n_checks++; if ({bus.pkt_valid, bus.pkt_type, bus.pkt_hdr, bus.pkt_addr, bus.pkt_hw, bus.pkt_len, bus.pkt_data} !== {1'b1, 2'd2, 8'h0B, 5'd1, 1'b0, 3'd4, 32'h44332211})
      $display("FAIL src_pkt got t=%0d h=%h a=%0d hw=%0b l=%0d d=%h want 2 0b 1 0 4 44332211", bus.pkt_type, bus.pkt_hdr, bus.pkt_addr, bus.pkt_hw, bus.pkt_len, bus.pkt_data); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_overflow_protocol();
    send(8'h70, 1'b1);
    n_checks++; if ({bus.pkt_valid, bus.pkt_type, bus.pkt_hdr, bus.pkt_len} !== {1'b1, 2'd1, 8'h70, 3'd0})
      $display("FAIL ovf_pkt got t=%0d h=%h l=%0d want 1 70 0", bus.pkt_type, bus.pkt_hdr, bus.pkt_len); else n_pass++;
    send(8'hC0, 1'b1);
    send(8'h85, 1'b1);
    n_checks++; if (bus.pkt_valid !== 1'b0) $display("FAIL proto_early got %0b want 0", bus.pkt_valid); else n_pass++;
    send(8'h03, 1'b1);
    n_checks++; if ({bus.pkt_valid, bus.pkt_type, bus.pkt_hdr, bus.pkt_addr, bus.pkt_len, bus.pkt_data} !== {1'b1, 2'd3, 8'hC0, 5'd0, 3'd2, 32'h00000385})
      $display("FAIL proto_pkt got t=%0d h=%h a=%0d l=%0d d=%h want 3 c0 0 2 00000385", bus.pkt_type, bus.pkt_hdr, bus.pkt_addr, bus.pkt_len, bus.pkt_data); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_sync_loss();
    send(8'hC0, 1'b1);
    repeat (4) send(8'h80, 1'b1);
    n_checks++; if ({bus.synced, bus.sync_lost, bus.pkt_valid} !== 3'b010)
      $display("FAIL sync_loss got s=%0b l=%0b v=%0b want 0 1 0", bus.synced, bus.sync_lost, bus.pkt_valid); else n_pass++;
    send(8'h09, 1'b1);
    send(8'h55, 1'b1);
    n_checks++; if ({bus.synced, bus.pkt_valid} !== 2'b00) $display("FAIL lost_ignored got %b want 00", {bus.synced, bus.pkt_valid}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    send_sync();
    n_checks++; if (bus.sync_lost !== 1'b1) $display("FAIL lost_sticky got %0b want 1", bus.sync_lost); else n_pass++;
    send(8'h09, 1'b0); send(8'hA1, 1'b0);
    send(8'h09, 1'b0); send(8'hA2, 1'b0);
    send(8'h09, 1'b0); send(8'hA3, 1'b0);
    n_checks++; if ({bus.pkt_valid, bus.pkt_type, bus.pkt_len, bus.pkt_data} !== {1'b1, 2'd2, 3'd1, 32'h000000A1})
      $display("FAIL held_pkt got v=%0b t=%0d l=%0d d=%h want 1 2 1 000000a1", bus.pkt_valid, bus.pkt_type, bus.pkt_len, bus.pkt_data); else n_pass++;
    n_checks++; if (bus.drop_count !== 8'd2) $display("FAIL drop_two got %0d want 2", bus.drop_count); else n_pass++;
    send(8'h09, 1'b0);
    send(8'hA4, 1'b1);
    n_checks++; if ({bus.pkt_valid, bus.pkt_data, bus.drop_count} !== {1'b1, 32'h000000A4, 8'd2})
      $display("FAIL same_cycle_load got v=%0b d=%h drop=%0d want 1 000000a4 2", bus.pkt_valid, bus.pkt_data, bus.drop_count); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1);
    n_checks++; if (bus.pkt_valid !== 1'b0) $display("FAIL drain got %0b want 0", bus.pkt_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    send_sync();
    send(8'h0B, 1'b1); send(8'h11, 1'b1); send(8'h22, 1'b1);
    assert_reset_mid();
    n_checks++; if ({bus.pkt_valid, bus.synced, bus.drop_count} !== {1'b0, 1'b0, 8'd0})
      $display("FAIL mid_reset got v=%0b s=%0b drop=%0d want 0 0 0", bus.pkt_valid, bus.synced, bus.drop_count); else n_pass++;
    release_reset();
    send(8'h33, 1'b1); send(8'h44, 1'b1); send(8'h09, 1'b1); send(8'h55, 1'b1);
    n_checks++; if ({bus.pkt_valid, bus.synced} !== 2'b00) $display("FAIL after_reset got %b want 00", {bus.pkt_valid, bus.synced}); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] burst[$];
    logic [7:0] b;
    bit         has, rdy;
    int         errs = 0;
    assert_reset_mid();
    release_reset();
    for (int i = 0; i < 4000; i++) begin
      if (burst.size() == 0 && $urandom_range(0, 30) == 0) begin
        repeat (5 + $urandom_range(0, 2)) burst.push_back(8'h00);
        burst.push_back(8'h80);
      end
      has = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (burst.size() != 0) begin
        b = burst.pop_front();
      end else begin
        case ($urandom_range(0, 9))
          0, 1:    b = 8'h00;
          2:       b = 8'h80;
          3:       b = 8'h70;
          4, 5:    b = 8'($urandom) | 8'h80;
          default: b = 8'($urandom);
        endcase
      end
      cycle(has, b, rdy);
      n_checks++;
      if ({bus.pkt_valid, bus.synced, bus.sync_lost, bus.drop_count} !== {m_valid, m_synced, m_lost, 8'(m_drop)}) begin
        if (errs < 10) $display("FAIL rnd_status cyc=%0d got v=%0b s=%0b l=%0b drop=%0d want %0b %0b %0b %0d", i,
          bus.pkt_valid, bus.synced, bus.sync_lost, bus.drop_count, m_valid, m_synced, m_lost, m_drop);
        errs++;
      end else n_pass++;
      if (m_valid) begin
        n_checks++;
        if ({bus.pkt_type, bus.pkt_hdr, bus.pkt_addr, bus.pkt_hw, bus.pkt_len, bus.pkt_data} !== m_slot) begin
          if (errs < 10) $display("FAIL rnd_pkt cyc=%0d got %h want %h", i,
            {bus.pkt_type, bus.pkt_hdr, bus.pkt_addr, bus.pkt_hw, bus.pkt_len, bus.pkt_data}, m_slot);
          errs++;
        end else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.byte_avail = 1'b0;
    bus.byte_in    = 8'h00;
    bus.pkt_ready  = 1'b0;
    m_reset();
    test_reset();
    test_sync();
    test_source();
    test_overflow_protocol();
    test_sync_loss();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
